// File: rtl/lanzones_pkg.sv
// lanzones shared definitions: RV32I opcodes, funct3/funct7 codes,
// controller states and ALU operations.
package lanzones_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE, FETCH, FWAIT, EXEC, LOAD, LWAIT, STORE, HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

endpackage

// File: rtl/lanzones_alu.sv
// lanzones combinational ALU with branch-compare flags on the same
// operands.
module lanzones_alu
  import lanzones_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, lt};
      ALU_SLTU: y = {31'd0, ltu};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/lanzones.sv
// lanzones: multi-cycle RV32I core, one instruction at a time over a
// single shared word-addressed memory port.
module lanzones
  import lanzones_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        LEn,
  output logic        RRdy,
  output logic [31:0] RAddr,
  input  logic        RVld,
  input  logic [31:0] RData,
  output logic        RWEn,
  output logic [31:0] RWData,
  output logic        Halt
);

  state_t      state, state_n;
  logic [31:0] pc, pc_n, ir, ir_n;
  logic [31:0] rf [32];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1v, rs2v, pc4, ea;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_y, wd;
  alu_op_t     aop;
  logic        eq, lt, ltu, we;
  logic        br_ok, br_take, imm_ok, op_ok;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25],
                  ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20],
                  ir[30:21], 1'b0};

  assign rs1v = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2v = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign pc4  = pc + 32'd4;
  // Shared adder: load/store address and JALR target.
  assign ea   = rs1v + ((opc == OP_STORE) ? imm_s : imm_i);

  assign alu_b = (opc == OP_OP || opc == OP_BRANCH) ? rs2v : imm_i;

  always_comb begin
    aop = ALU_ADD;
    unique case (f3)
      F3_ADD:  aop = (opc == OP_OP && f7 == F7_ALT) ? ALU_SUB
                                                    : ALU_ADD;
      F3_SLL:  aop = ALU_SLL;
      F3_SLT:  aop = ALU_SLT;
      F3_SLTU: aop = ALU_SLTU;
      F3_XOR:  aop = ALU_XOR;
      F3_SR:   aop = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      F3_OR:   aop = ALU_OR;
      F3_AND:  aop = ALU_AND;
      default: aop = ALU_ADD;
    endcase
  end

  lanzones_alu u_alu (
    .op  (aop),
    .a   (rs1v),
    .b   (alu_b),
    .y   (alu_y),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  assign imm_ok = !((f3 == F3_SLL && f7 != F7_BASE) ||
                    (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT));
  assign op_ok  = (f7 == F7_BASE) ||
                  (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
  assign br_ok  = (f3 != 3'b010) && (f3 != 3'b011);

  always_comb begin
    br_take = 1'b0;
    unique case (f3)
      F3_BEQ:  br_take = eq;
      F3_BNE:  br_take = !eq;
      F3_BLT:  br_take = lt;
      F3_BGE:  br_take = !lt;
      F3_BLTU: br_take = ltu;
      F3_BGEU: br_take = !ltu;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    we      = 1'b0;
    wd      = '0;
    case (state)
      IDLE:  if (LEn) state_n = FETCH;
      FETCH: state_n = FWAIT;
      FWAIT: begin
        if (RVld) begin
          ir_n    = RData;
          state_n = EXEC;
        end
      end
      EXEC: begin
        state_n = FETCH;
        pc_n    = pc4;
        unique case (1'b1)
          opc == OP_LUI: begin
            we = 1'b1;
            wd = imm_u;
          end
          opc == OP_AUIPC: begin
            we = 1'b1;
            wd = pc + imm_u;
          end
          opc == OP_JAL: begin
            we   = 1'b1;
            wd   = pc4;
            pc_n = pc + imm_j;
          end
          opc == OP_JALR && f3 == F3_ADD: begin
            we   = 1'b1;
            wd   = pc4;
            pc_n = {ea[31:1], 1'b0};
          end
          opc == OP_BRANCH && br_ok: begin
            if (br_take) pc_n = pc + imm_b;
          end
          opc == OP_LOAD && f3 == F3_W: begin
            state_n = LOAD;
            pc_n    = pc;
          end
          opc == OP_STORE && f3 == F3_W: begin
            state_n = STORE;
            pc_n    = pc;
          end
          opc == OP_IMM && imm_ok,
          opc == OP_OP && op_ok: begin
            we = 1'b1;
            wd = alu_y;
          end
          opc == OP_FENCE && f3 == 3'b000: ;
          default: begin
            state_n = HALT;
            pc_n    = pc;
          end
        endcase
      end
      LOAD:  state_n = LWAIT;
      LWAIT: begin
        if (RVld) begin
          we      = 1'b1;
          wd      = RData;
          pc_n    = pc4;
          state_n = FETCH;
        end
      end
      STORE: begin
        pc_n    = pc4;
        state_n = FETCH;
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && rd != 5'd0) begin
      rf[rd] <= wd;
    end
  end

  assign RRdy   = (state == FETCH) || (state == LOAD);
  assign RWEn   = (state == STORE);
  assign Halt   = (state == HALT);
  assign RAddr  = (state == FETCH) ? (pc >> 2) :
                  (state == LOAD || state == STORE) ? (ea >> 2) : '0;
  assign RWData = (state == STORE) ? rs2v : '0;

endmodule

// File: tb/tb_lanzones.sv
// lanzones bench: directed programs plus random ALU programs checked
// against an instruction-level reference interpreter.
module tb_lanzones;

  logic        clk, rstn, LEn, RRdy, RVld, RWEn, Halt;
  logic [31:0] RAddr, RData, RWData;

  logic [31:0] mem [0:1023];
  logic [31:0] rm  [0:1023];
  logic [31:0] alog [$];
  int          checks, errors, nwr, viol, cnt;
  bit          pend, prev_rrdy;
  logic [9:0]  paddr;

  lanzones dut (
    .clk    (clk),
    .rstn   (rstn),
    .LEn    (LEn),
    .RRdy   (RRdy),
    .RAddr  (RAddr),
    .RVld   (RVld),
    .RData  (RData),
    .RWEn   (RWEn),
    .RWData (RWData),
    .Halt   (Halt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Memory with random read latency; also watches the handshake rules.
  initial begin
    RVld = 0; RData = 0; pend = 0; prev_rrdy = 0; cnt = 0; paddr = 0;
    forever begin
      @(negedge clk);
      RVld  = 0;
      RData = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          RVld  = 1;
          RData = mem[paddr];
          pend  = 0;
        end else cnt--;
      end
      if (RRdy) begin
        if (prev_rrdy) viol++;
        pend  = 1;
        paddr = RAddr[9:0];
        cnt   = $urandom_range(0, 2);
        alog.push_back(RAddr);
      end
      if (RWEn) begin
        mem[RAddr[9:0]] = RWData;
        nwr++;
      end
      if (RRdy && (RWEn || RVld)) viol++;
      if (RAddr[31:30] != 2'b00) viol++;
      prev_rrdy = RRdy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ei(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] es(input logic [11:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] eb(input logic [12:0] off,
    input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] er(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] eu(input logic [19:0] imm,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] ej(input logic [20:0] off,
    input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  localparam logic [31:0] ECALL = 32'h0000_0073;

  function automatic logic [31:0] alu_ref(input logic [2:0] f,
    input bit alt, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Instruction-set interpreter over rm[], starting from reset state.
  task automatic model_run();
    logic [31:0] x [32];
    logic [31:0] pc, ins, a, b, iv, res, nxt, ea;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit stop, wen, tk;
    for (int i = 0; i < 32; i++) x[i] = 0;
    pc = 0; stop = 0;
    for (int s = 0; s < 4000 && !stop; s++) begin
      ins = rm[pc[11:2]];
      op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
      a = x[ins[19:15]]; b = x[ins[24:20]];
      iv = {{20{ins[31]}}, ins[31:20]};
      wen = 0; res = 0; nxt = pc + 4; tk = 0;
      case (op)
        7'h37: begin wen = 1; res = {ins[31:12], 12'd0}; end
        7'h17: begin wen = 1; res = pc + {ins[31:12], 12'd0}; end
        7'h6f: begin
          wen = 1; res = pc + 4;
          nxt = pc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                      ins[30:21], 1'b0};
        end
        7'h67: if (f3 == 0) begin
          wen = 1; res = pc + 4; nxt = (a + iv) & ~32'd1;
        end else stop = 1;
        7'h63: begin
          case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: stop = 1;
          endcase
          if (tk) nxt = pc + {{19{ins[31]}}, ins[31], ins[7],
                              ins[30:25], ins[11:8], 1'b0};
        end
        7'h03: if (f3 == 2) begin
          ea = a + iv; wen = 1; res = rm[ea[11:2]];
        end else stop = 1;
        7'h23: if (f3 == 2) begin
          ea = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
          rm[ea[11:2]] = b;
        end else stop = 1;
        7'h13: if ((f3 == 1 && f7 != 0) ||
                   (f3 == 5 && f7 != 0 && f7 != 7'h20)) stop = 1;
               else begin
                 wen = 1; res = alu_ref(f3, f3 == 5 && f7 == 7'h20, a, iv);
               end
        7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                 wen = 1; res = alu_ref(f3, f7 == 7'h20, a, b);
               end else stop = 1;
        7'h0f: if (f3 != 0) stop = 1;
        default: stop = 1;
      endcase
      if (!stop) begin
        if (wen && rd != 0) x[rd] = res;
        pc = nxt;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 0;
  endtask

  task automatic do_reset();
    #1 rstn = 0; LEn = 0;
    repeat (3) @(negedge clk);
    #1 rstn = 1;
    @(negedge clk);
  endtask

  task automatic pulse_len();
    @(negedge clk); #1 LEn = 1;
    @(negedge clk); #1 LEn = 0;
  endtask

  task automatic launch_wait(input string tag, input int budget);
    int n;
    for (int i = 0; i < 1024; i++) rm[i] = mem[i];
    model_run();
    alog.delete(); nwr = 0;
    pulse_len();
    n = 0;
    while (!Halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halt"}, {31'd0, Halt}, 32'd1);
  endtask

  function automatic logic [31:0] fetch_at(input int i);
    return (alog.size() > i) ? alog[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [31:0] w;
    logic [11:0] imm12;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    int          pcw;
    checks = 0; errors = 0; nwr = 0; viol = 0;
    rstn = 0; LEn = 0;

    // Test 1/2: store of an immediate, fetch pulse ordering
    clear_mem();
    mem[0] = ei(12'd5, 0, 3'd0, 1, 7'h13);
    mem[1] = es(12'h400, 1, 0);
    mem[2] = ECALL;
    do_reset();
    repeat (3) @(negedge clk);
    chk("idle_rrdy", {31'd0, RRdy}, 0);
    chk("idle_halt", {31'd0, Halt}, 0);
    chk("idle_rwen", {31'd0, RWEn}, 0);
    chk("idle_raddr", RAddr, 0);
    launch_wait("t1", 500);
    chk("t1_mem100", mem[10'h100], 32'd5);
    chk("t1_model", mem[10'h100], rm[10'h100]);
    chk("t1_writes", nwr, 1);
    chk("t1_nfetch", alog.size(), 3);
    chk("t1_fetch0", fetch_at(0), 0);
    chk("t1_fetch1", fetch_at(1), 1);

    // Test 3: load, increment, store
    clear_mem();
    mem[0] = ei(12'h404, 0, 3'd2, 2, 7'h03);
    mem[1] = ei(12'd1, 2, 3'd0, 2, 7'h13);
    mem[2] = es(12'h408, 2, 0);
    mem[3] = ECALL;
    mem[10'h101] = 32'hDEAD_BEEF;
    do_reset();
    launch_wait("t3", 500);
    chk("t3_mem102", mem[10'h102], 32'hDEAD_BEF0);
    chk("t3_writes", nwr, 1);
    chk("t3_addrs", alog.size(), 5);

    // Test 4: counted loop, JAL/JALR link
    clear_mem();
    mem[0] = ei(12'd3, 0, 3'd0, 1, 7'h13);
    mem[1] = ei(12'd0, 0, 3'd0, 3, 7'h13);
    mem[2] = ei(12'd1, 3, 3'd0, 3, 7'h13);
    mem[3] = ei(12'hFFF, 1, 3'd0, 1, 7'h13);
    mem[4] = eb(13'h1FF8, 0, 1, 3'b001);
    mem[5] = es(12'h40C, 3, 0);
    mem[6] = ej(21'd12, 5);
    mem[7] = es(12'h410, 5, 0);
    mem[8] = ECALL;
    mem[9] = ei(12'd0, 5, 3'd0, 0, 7'h67);
    do_reset();
    launch_wait("t4", 800);
    chk("t4_count", mem[10'h103], 32'd3);
    chk("t4_link", mem[10'h104], 32'd28);
    chk("t4_model", mem[10'h104], rm[10'h104]);
    chk("t4_writes", nwr, 2);

    // Test 5: SUB, SRA, SLTU/SLT signedness, x0 write discard
    clear_mem();
    mem[0]  = ei(12'd10, 0, 3'd0, 1, 7'h13);
    mem[1]  = ei(12'd3, 0, 3'd0, 2, 7'h13);
    mem[2]  = er(7'h20, 2, 1, 3'd0, 3);
    mem[3]  = eu(20'h80000, 4, 7'h37);
    mem[4]  = ei(12'd4, 0, 3'd0, 5, 7'h13);
    mem[5]  = er(7'h20, 5, 4, 3'd5, 6);
    mem[6]  = ei(12'hFFF, 0, 3'd0, 7, 7'h13);
    mem[7]  = ei(12'd1, 0, 3'd0, 8, 7'h13);
    mem[8]  = er(7'h00, 8, 7, 3'd3, 9);
    mem[9]  = er(7'h00, 8, 7, 3'd2, 10);
    mem[10] = ei(12'd7, 0, 3'd0, 0, 7'h13);
    mem[11] = es(12'h414, 6, 0);
    mem[12] = es(12'h418, 9, 0);
    mem[13] = es(12'h41C, 10, 0);
    mem[14] = es(12'h420, 0, 0);
    mem[15] = es(12'h424, 3, 0);
    mem[16] = ECALL;
    for (int i = 10'h105; i <= 10'h109; i++) mem[i] = 32'hAAAA_5555;
    do_reset();
    launch_wait("t5", 800);
    chk("t5_sra", mem[10'h105], 32'hF800_0000);
    chk("t5_sltu", mem[10'h106], 32'd0);
    chk("t5_slt", mem[10'h107], 32'd1);
    chk("t5_x0", mem[10'h108], 32'd0);
    chk("t5_sub", mem[10'h109], 32'd7);
    chk("t5_writes", nwr, 5);

    // Test 6: illegal word halts, halt is sticky
    clear_mem();
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = es(12'h400, 0, 0);
    do_reset();
    launch_wait("t6_ill", 200);
    chk("t6_ill_writes", nwr, 0);
    chk("t6_ill_fetch", alog.size(), 1);
    pulse_len();
    repeat (5) @(negedge clk);
    chk("t6_sticky", {31'd0, Halt}, 1);
    chk("t6_sticky_fetch", alog.size(), 1);

    // Test 6: reset during a fetch, then a clean relaunch
    clear_mem();
    mem[0] = ei(12'd5, 0, 3'd0, 1, 7'h13);
    mem[1] = es(12'h400, 1, 0);
    mem[2] = ECALL;
    do_reset();
    alog.delete();
    @(negedge clk); #1 LEn = 1;
    @(negedge clk); #1 LEn = 0;
    chk("t6_rrdy_up", {31'd0, RRdy}, 1);
    #1 rstn = 0;
    #1 chk("t6_rrdy_rst", {31'd0, RRdy}, 0);
    chk("t6_raddr_rst", RAddr, 0);
    @(negedge clk); #1 rstn = 1;
    repeat (6) @(negedge clk);
    chk("t6_idle_fetch", alog.size(), 1);
    chk("t6_idle_halt", {31'd0, Halt}, 0);
    launch_wait("t6_relaunch", 500);
    chk("t6_relaunch_mem", mem[10'h100], 32'd5);

    // Random ALU programs against the interpreter
    for (int t = 0; t < 3; t++) begin
      clear_mem();
      pcw = 0;
      for (int k = 0; k < 24; k++) begin
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        imm12 = 12'($urandom);
        case ($urandom_range(0, 3))
          0: w = er(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1)
                    ? 7'h20 : 7'h00, r2, r1, f3, rd);
          1: begin
            if (f3 == 1) imm12 = {7'h00, imm12[4:0]};
            if (f3 == 5) imm12 = {imm12[10] ? 7'h20 : 7'h00, imm12[4:0]};
            w = ei(imm12, r1, f3, rd, 7'h13);
          end
          2: w = eu(20'($urandom), rd, 7'h37);
          default: w = eu(20'($urandom), rd, 7'h17);
        endcase
        mem[pcw] = w;
        pcw++;
      end
      for (int i = 1; i <= 7; i++) begin
        mem[pcw] = es(12'h600 + 12'(4 * (i - 1)), 5'(i), 0);
        pcw++;
      end
      mem[pcw] = ECALL;
      do_reset();
      launch_wait($sformatf("rnd%0d", t), 1500);
      for (int i = 0; i < 7; i++)
        chk($sformatf("rnd%0d_x%0d", t, i + 1),
            mem[10'h180 + i], rm[10'h180 + i]);
      chk($sformatf("rnd%0d_writes", t), nwr, 7);
    end

    chk("handshake", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
